// File: rtl/channel_stream_driver_pkg.sv
// Shared types and constants for the channel stream driver.
// Sample width, matrix size, FSM encoding and index helper.
package channel_stream_driver_pkg;

  localparam int BIT_NUM      = 18;
  localparam int CHANNEL_SIZE = 16;
  localparam int IDX_W        = $clog2(CHANNEL_SIZE);
  localparam int CNT_W        = IDX_W + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND    = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  function automatic logic [IDX_W-1:0] idx(
    input logic [1:0] row,
    input logic [1:0] col
  );
    return {row, col};
  endfunction

endpackage

// File: rtl/channel_stream_driver_buf16.sv
// stream_buf16: 16-entry complex register file, sync clear.
// Ports: one write port (we/waddr/wr_*), one async read (raddr/rd_*).
module stream_buf16
  import channel_stream_driver_pkg::*;
#(
  parameter int W = BIT_NUM
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [W-1:0]     wr_R,
  input  logic [W-1:0]     wr_I,
  input  logic [IDX_W-1:0] raddr,
  output logic [W-1:0]     rd_R,
  output logic [W-1:0]     rd_I
);

  logic [W-1:0] mem_R [CHANNEL_SIZE];
  logic [W-1:0] mem_I [CHANNEL_SIZE];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNEL_SIZE; i++) begin
        mem_R[i] <= '0;
        mem_I[i] <= '0;
      end
    end else if (we) begin
      mem_R[waddr] <= wr_R;
      mem_I[waddr] <= wr_I;
    end
  end

  assign rd_R = mem_R[raddr];
  assign rd_I = mem_I[raddr];

endmodule

// File: rtl/channel_stream_driver.sv
// Host endpoint: streams a 4x4 complex matrix out, captures result.
// Ports: host load, start, tx stream, rx stream, done/timeout, read.
module channel_stream_driver
  import channel_stream_driver_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_we,
  input  logic [IDX_W-1:0]   load_addr,
  input  logic [BIT_NUM-1:0] load_R,
  input  logic [BIT_NUM-1:0] load_I,
  input  logic               start,
  output logic               busy,
  output logic               tx_valid_o,
  output logic [BIT_NUM-1:0] tx_R_o,
  output logic [BIT_NUM-1:0] tx_I_o,
  input  logic               rx_valid_i,
  input  logic [BIT_NUM-1:0] rx_R_i,
  input  logic [BIT_NUM-1:0] rx_I_i,
  output logic               done,
  output logic               timeout,
  input  logic [IDX_W-1:0]   rd_addr,
  output logic [BIT_NUM-1:0] rd_R,
  output logic [BIT_NUM-1:0] rd_I
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] N_ALL =
    CNT_W'(CHANNEL_SIZE);
  localparam logic [CNT_W-1:0] N_LAST =
    CNT_W'(CHANNEL_SIZE - 1);

  state_t state, state_n;

  logic [CNT_W-1:0] tx_cnt;
  logic [CNT_W-1:0] rx_cnt;
  logic [WD_W-1:0]  wd;
  logic             timeout_q;

  logic             host_we;
  logic             rx_we;
  logic             to_hit;
  logic             go;
  logic             sending;

  logic [IDX_W-1:0]   tx_raddr;
  logic [BIT_NUM-1:0] tx_buf_R;
  logic [BIT_NUM-1:0] tx_buf_I;
  logic [BIT_NUM-1:0] res_buf_R;
  logic [BIT_NUM-1:0] res_buf_I;

  always_comb begin
    state_n = state;
    host_we = 1'b0;
    rx_we   = 1'b0;
    to_hit  = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        host_we = load_we;
        if (start) state_n = SEND;
      end
      SEND: begin
        if (tx_cnt == N_ALL) state_n = WAIT;
      end
      WAIT: begin
        if (rx_valid_i) begin
          rx_we   = 1'b1;
          state_n = CAPTURE;
        end
        if (wd == WD_LAST) begin
          state_n = DONE;
          to_hit  = 1'b1;
        end
      end
      CAPTURE: begin
        rx_we = rx_valid_i;
        // Completion takes priority over the watchdog.
        if (rx_valid_i && rx_cnt == N_LAST) begin
          state_n = DONE;
        end else if (wd == WD_LAST) begin
          state_n = DONE;
          to_hit  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Next cycle presents a tx element; also marks start acceptance.
  assign sending = (state_n == SEND);
  assign go      = sending && (state != SEND);

  // On the start edge the read index is 0; afterwards tx_cnt leads
  // the registered output by one element.
  assign tx_raddr = (state == SEND) ? tx_cnt[IDX_W-1:0] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx_cnt     <= '0;
      rx_cnt     <= '0;
      wd         <= '0;
      timeout_q  <= 1'b0;
      tx_valid_o <= 1'b0;
      tx_R_o     <= '0;
      tx_I_o     <= '0;
      rd_R       <= '0;
      rd_I       <= '0;
    end else begin
      state      <= state_n;
      tx_valid_o <= sending;
      tx_R_o     <= sending ? tx_buf_R : '0;
      tx_I_o     <= sending ? tx_buf_I : '0;
      if (sending)
        tx_cnt <= go ? CNT_W'(1) : tx_cnt + 1'b1;
      else
        tx_cnt <= '0;
      if (go)
        rx_cnt <= '0;
      else if (rx_we)
        rx_cnt <= rx_cnt + 1'b1;
      if (state == WAIT || state == CAPTURE)
        wd <= wd + 1'b1;
      else
        wd <= '0;
      if (go)
        timeout_q <= 1'b0;
      else if (to_hit)
        timeout_q <= 1'b1;
      rd_R <= res_buf_R;
      rd_I <= res_buf_I;
    end
  end

  assign busy    = (state == SEND) || (state == WAIT) ||
                   (state == CAPTURE);
  assign done    = (state == DONE);
  assign timeout = timeout_q;

  stream_buf16 #(.W(BIT_NUM)) tx_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (host_we),
    .waddr (load_addr),
    .wr_R  (load_R),
    .wr_I  (load_I),
    .raddr (tx_raddr),
    .rd_R  (tx_buf_R),
    .rd_I  (tx_buf_I)
  );

  stream_buf16 #(.W(BIT_NUM)) res_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (rx_we),
    .waddr (rx_cnt[IDX_W-1:0]),
    .wr_R  (rx_R_i),
    .wr_I  (rx_I_i),
    .raddr (rd_addr),
    .rd_R  (res_buf_R),
    .rd_I  (res_buf_I)
  );

endmodule

// File: tb/tb_channel_stream_driver.sv
// Scoreboard bench for channel_stream_driver.
// Stimulus pushes expected samples; a negedge monitor pops them.
module tb_channel_stream_driver;
  import channel_stream_driver_pkg::*;

  logic clk = 1'b0;
  logic rst, load_we, start, rx_valid_i;
  logic [3:0] load_addr, rd_addr;
  logic [17:0] load_R, load_I, rx_R_i, rx_I_i;
  logic busy, tx_valid_o, done, timeout;
  logic [17:0] tx_R_o, tx_I_o, rd_R, rd_I;

  always #5 clk = ~clk;

  channel_stream_driver #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst),
    .load_we(load_we), .load_addr(load_addr),
    .load_R(load_R), .load_I(load_I),
    .start(start), .busy(busy),
    .tx_valid_o(tx_valid_o),
    .tx_R_o(tx_R_o), .tx_I_o(tx_I_o),
    .rx_valid_i(rx_valid_i),
    .rx_R_i(rx_R_i), .rx_I_i(rx_I_i),
    .done(done), .timeout(timeout),
    .rd_addr(rd_addr), .rd_R(rd_R), .rd_I(rd_I)
  );

  typedef struct packed {
    logic [17:0] r;
    logic [17:0] i;
  } samp_t;

  samp_t tx_q[$];
  samp_t rd_q[$];
  samp_t mon_e;
  logic [17:0] mR [16];
  logic [17:0] mI [16];
  int n_vec = 0;
  int n_bad = 0;
  logic rd_req = 1'b0;
  logic rd_req_d = 1'b0;

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  always @(posedge clk) rd_req_d <= rd_req;

  always @(negedge clk) begin
    if (tx_valid_o) begin
      if (tx_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL tx_extra: got R=%0d, expected no valid",
                 $signed(tx_R_o));
      end else begin
        mon_e = tx_q.pop_front();
        chk("tx_R", $signed(tx_R_o), $signed(mon_e.r));
        chk("tx_I", $signed(tx_I_o), $signed(mon_e.i));
      end
    end
    if (rd_req_d && rd_q.size() != 0) begin
      mon_e = rd_q.pop_front();
      chk("rd_R", $signed(rd_R), $signed(mon_e.r));
      chk("rd_I", $signed(rd_I), $signed(mon_e.i));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rd(input int a, input int er, input int ei);
    rd_addr = 4'(a);
    rd_req  = 1'b1;
    rd_q.push_back({18'(er), 18'(ei)});
    tick();
    rd_req = 1'b0;
  endtask

  task automatic load_matrix();
    for (int k = 0; k < 16; k++) begin
      load_we   = 1'b1;
      load_addr = 4'(k);
      load_R    = 18'(k + 1);
      load_I    = 18'(-(k + 1));
      mR[k]     = 18'(k + 1);
      mI[k]     = 18'(-(k + 1));
      tick();
    end
    load_we = 1'b0;
  endtask

  // Returns at the first negedge in WAIT.
  task automatic transmit(input bit poke);
    int n;
    for (int k = 0; k < 16; k++)
      tx_q.push_back({mR[k], mI[k]});
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_tx", busy, 1);
    chk("done_clr", done, 0);
    chk("to_clr", timeout, 0);
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (tx_valid_o) n++;
      if (poke && i == 4) begin
        load_we = 1'b1; load_addr = 4'd0;
        load_R = 18'd77; load_I = 18'd77;
        start = 1'b1;
        rx_valid_i = 1'b1;
        rx_R_i = 18'd888; rx_I_i = 18'd888;
      end else begin
        load_we = 1'b0;
        start = 1'b0;
        rx_valid_i = 1'b0;
      end
      tick();
    end
    chk("tx_len", n, 16);
    chk("tx_tail", tx_valid_o, 0);
    chk("tx_zero_R", tx_R_o, 0);
    chk("tx_zero_I", tx_I_o, 0);
    chk("busy_wait", busy, 1);
  endtask

  task automatic rx_burst(input int base,
                          input bit gaps,
                          input bit extra);
    for (int k = 0; k < 16; k++) begin
      if (gaps && (k == 4 || k == 9 || k == 13)) begin
        rx_valid_i = 1'b0;
        tick();
      end
      rx_valid_i = 1'b1;
      rx_R_i = 18'(base + k);
      rx_I_i = 18'(base + 100 + k);
      if (k == 15) chk("done_early", done, 0);
      tick();
    end
    if (extra) begin
      rx_valid_i = 1'b1;
      rx_R_i = 18'd999;
      rx_I_i = 18'd999;
    end else begin
      rx_valid_i = 1'b0;
    end
    chk("done_rx", done, 1);
    chk("timeout_rx", timeout, 0);
    chk("busy_done", busy, 0);
    tick();
    rx_valid_i = 1'b0;
    chk("done_hold", done, 1);
  endtask

  // Entered at the first negedge in WAIT.
  task automatic wait_timeout(input bit poke);
    for (int i = 0; i < 63; i++) begin
      start = poke && (i == 2 || i == 20);
      load_we = poke && (i == 2);
      load_addr = 4'd0;
      load_R = 18'd77;
      load_I = 18'd77;
      tick();
    end
    start = 1'b0;
    load_we = 1'b0;
    chk("to_early", done, 0);
    tick();
    chk("to_done", done, 1);
    chk("to_flag", timeout, 1);
    chk("to_busy", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; load_we = 1'b0; start = 1'b0;
    rx_valid_i = 1'b0; load_addr = '0; rd_addr = '0;
    load_R = '0; load_I = '0; rx_R_i = '0; rx_I_i = '0;
    repeat (3) tick();
    chk("rst_valid", tx_valid_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_to", timeout, 0);
    chk("rst_txR", tx_R_o, 0);
    rst = 1'b0;
    rd(3, 0, 0);

    load_matrix();
    transmit(0);
    rx_burst(100, 0, 0);
    rd(5, 105, 205);
    rd(0, 100, 200);
    rd(15, 115, 215);

    transmit(0);
    rx_burst(300, 1, 1);
    rd(15, 315, 415);
    rd(14, 314, 414);

    transmit(1);
    wait_timeout(1);
    rd(0, 300, 400);
    rd(5, 305, 405);

    transmit(0);
    rx_burst(500, 0, 0);
    rd(0, 500, 600);

    for (int k = 0; k < 16; k++)
      tx_q.push_back({mR[k], mI[k]});
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    chk("abort_valid", tx_valid_o, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    rst = 1'b0;
    tx_q.delete();
    for (int k = 0; k < 16; k++) begin
      mR[k] = '0;
      mI[k] = '0;
    end
    rd(3, 0, 0);
    transmit(0);
    wait_timeout(0);
    rd(7, 0, 0);
    tick();
    chk("tx_q_empty", tx_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/channel_stream_driver.md
Name: channel_stream_driver

Overview:
Host-side endpoint for the 4x4 complex bidiagonalization processor.
- Holds one 4x4 complex channel matrix loaded by the host.
- On start, streams the matrix to the processor as a 16-sample valid burst.
- Captures the processor's 16-sample result burst into a result buffer and exposes it through a read port.
- Flags a timeout if the result never arrives.
- Sits between host/testbench logic and the processor's valid_i/R_i/I_i inputs and valid_o/R_o/I_o outputs.

Parameters:
BIT_NUM, 18, width of each real/imag sample (signed)
CHANNEL_SIZE, 16, samples per matrix (4x4, index = {row[1:0],col[1:0]})
TIMEOUT_CYCLES, 64, max cycles allowed from end of transmit to last result sample

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
load_we  in  1  write one matrix element (ignored while busy)
load_addr  in  4  element index {row,col}
load_R  in  BIT_NUM  element real part, signed
load_I  in  BIT_NUM  element imag part, signed
start  in  1  begin transmit/capture; honoured only in IDLE or DONE
busy  out  1  high in SEND, WAIT, CAPTURE
tx_valid_o  out  1  drives processor valid_i
tx_R_o  out  BIT_NUM  drives processor R_i
tx_I_o  out  BIT_NUM  drives processor I_i
rx_valid_i  in  1  from processor valid_o
rx_R_i  in  BIT_NUM  from processor R_o
rx_I_i  in  BIT_NUM  from processor I_o
done  out  1  result set complete (level, held until next start or rst)
timeout  out  1  DONE reached via watchdog (level, same lifetime as done)
rd_addr  in  4  result buffer read index
rd_R  out  BIT_NUM  result real part, 1-cycle read latency
rd_I  out  BIT_NUM  result imag part, 1-cycle read latency

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high (rst); everything sampled on posedge clk.
- Reset values: all outputs 0; state IDLE; counters 0; tx and result buffers cleared to 0.
- rst asserted mid-operation aborts immediately. tx_valid_o is low from the next edge, even mid-burst.
- States: IDLE, SEND, WAIT, CAPTURE, DONE.
- IDLE:
  - load_we writes tx_buf[load_addr].
  - start -> SEND.
- SEND:
  - All tx outputs are registered.
  - The first cycle after the start edge drives tx_valid_o=1 with element 0.
  - Then one element per cycle, index 0..15 ascending, with no gaps: exactly 16 consecutive valid cycles.
  - After element 15, tx_valid_o=0 and tx_R_o/tx_I_o=0 on the next cycle; state -> WAIT. The valid fall is what triggers the processor's compute phase.
  - load_we and start are ignored.
- WAIT:
  - The watchdog counter starts at 0 on entry and increments every cycle in WAIT/CAPTURE.
  - rx_valid_i=1 captures rx sample into res_buf[0], sets rx_cnt=1, state -> CAPTURE.
- CAPTURE:
  - Each rx_valid_i=1 cycle writes res_buf[rx_cnt] and increments rx_cnt.
  - Gaps (rx_valid_i=0) are tolerated.
  - rx_cnt reaching 16 -> DONE with done=1 and timeout=0.
  - rx samples beyond 16 are never written.
- Watchdog: counter == TIMEOUT_CYCLES-1 while still in WAIT/CAPTURE -> DONE with done=1 and timeout=1. Buffers keep the partial result and unwritten entries keep their old value.
- Simultaneous 16th sample and watchdog expiry: completion wins (timeout=0).
- rx_valid_i in IDLE, SEND or DONE is ignored (no buffer write).
- DONE:
  - load_we is accepted, so the host can reload.
  - start -> SEND, clears done/timeout and rx_cnt, and retransmits the current tx_buf.
- Read port: rd_R/rd_I return res_buf[rd_addr] one cycle later, in any state.
- Arithmetic: no arithmetic on samples; values pass through bit-exact as signed BIT_NUM.
- Counter widths: tx/rx counters are $clog2(CHANNEL_SIZE)+1 bits so the value 16 is representable; watchdog is $clog2(TIMEOUT_CYCLES) bits.

Decomposition:
- Shared package holds:
  - BIT_NUM, CHANNEL_SIZE;
  - the state encoding (IDLE=0, SEND=1, WAIT=2, CAPTURE=3, DONE=4);
  - an index helper forming {row,col}.
- One natural sub-module: stream_buf16, a 16-entry dual-port complex register file with synchronous clear. Instantiate it twice: tx_buf (host write, sequencer read) and res_buf (capture write, rd port read).

Test Plan:
- Load element k with R=k+1, I=-(k+1); pulse start -> tx_valid_o high for exactly 16 consecutive cycles starting 1 cycle after start, tx_R_o=1..16, tx_I_o=-1..-16, then low; busy=1.
- After transmit, drive rx burst of 16 with R=100+k, I=200+k -> done=1 the cycle after the 16th sample; rd_addr=5 gives rd_R=105, rd_I=205 one cycle later; timeout=0.
- rx burst with 3 idle gaps inside, then a 17th sample R=999 -> done after the 16th sample; res_buf[15] not overwritten by 999.
- No rx_valid_i after transmit -> done=1 and timeout=1 exactly 64 cycles after entering WAIT; rd of any entry returns its prior value (0 after reset).
- load_we to addr 0 with R=77 during SEND, and start pulses during SEND/WAIT -> ignored: the next retransmit shows the original element 0, and no restart occurs.
- rst asserted at the 8th transmit cycle -> the next edge shows tx_valid_o=0, busy=0, done=0; then start without reload -> transmits all zeros.
